// File: rtl/rst_req_seq.sv
// rtl/rst_req_seq.sv - reset-request sequencer: per-domain hold, then staggered release
// A request is held for HOLD_CYCLES, then its domains are released one at a time, lowest index first.
module rst_req_seq #(
    parameter int NUM_DOM     = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int GAP_CYCLES  = 8
) (
    input  logic               ref_clk_i,
    input  logic               srst_i,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [NUM_DOM-1:0] req_mask_i,
    output logic [NUM_DOM-1:0] arst_req_o,
    output logic               busy_o,
    output logic               done_o
);

    localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);

    if (NUM_DOM < 1 || HOLD_CYCLES < 1 || GAP_CYCLES < 1) begin : g_bad_param
        $fatal(1, "rst_req_seq: NUM_DOM, HOLD_CYCLES and GAP_CYCLES must all be >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_GAP,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [NUM_DOM-1:0] pend_q, pend_d;
    logic               from_req_q, from_req_d;
    logic [NUM_DOM-1:0] pend_rel;
    logic               ready_q, busy_q, done_q;

    // Clearing the lowest set bit releases the next domain in ascending order.
    assign pend_rel = pend_q & (pend_q - NUM_DOM'(1));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        from_req_d = from_req_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    from_req_d = 1'b1;
                    cnt_d      = '0;
                    if (|req_mask_i) begin
                        pend_d  = req_mask_i;
                        state_d = S_HOLD;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_HOLD, S_GAP: begin
                if (pend_q == '0) begin
                    // Request sequences spend one cycle after the final fall before reporting done.
                    state_d = S_DONE;
                end else if (cnt_q == ((state_q == S_HOLD) ? HOLD_LAST : GAP_LAST)) begin
                    pend_d  = pend_rel;
                    cnt_d   = '0;
                    state_d = (pend_rel == '0 && !from_req_q) ? S_DONE : S_GAP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                state_d    = S_IDLE;
                from_req_d = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge ref_clk_i) begin
        if (srst_i) begin
            state_q    <= S_HOLD;
            cnt_q      <= '0;
            pend_q     <= '1;
            from_req_q <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            from_req_q <= from_req_d;
            ready_q    <= (state_d == S_IDLE);
            busy_q     <= (state_d != S_IDLE);
            done_q     <= (state_d == S_DONE) && from_req_d;
        end
    end

    assign arst_req_o  = pend_q;
    assign req_ready_o = ready_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_rst_req_seq.sv
// tb/tb_rst_req_seq.sv - scoreboard bench for rst_req_seq (default and 1/1 timing instances)
module tb_rst_req_seq;

    localparam int ND = 4;

    typedef struct {
        int kind;   // 0 = domain fall, 1 = done pulse, 2 = ready rise (idx holds busy)
        int idx;
        int cyc;
    } ev_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          srst  [2];
    logic          valid [2];
    logic [ND-1:0] mask  [2];
    logic [ND-1:0] arst  [2];
    logic          ready [2];
    logic          busy  [2];
    logic          done  [2];

    ev_t sbq [2][$];
    int  passed = 0;
    int  total  = 0;
    bit  mon_on = 1'b0;

    rst_req_seq #(.NUM_DOM(ND), .HOLD_CYCLES(16), .GAP_CYCLES(8)) dut0 (
        .ref_clk_i(clk), .srst_i(srst[0]), .req_valid_i(valid[0]), .req_ready_o(ready[0]),
        .req_mask_i(mask[0]), .arst_req_o(arst[0]), .busy_o(busy[0]), .done_o(done[0])
    );

    rst_req_seq #(.NUM_DOM(ND), .HOLD_CYCLES(1), .GAP_CYCLES(1)) dut1 (
        .ref_clk_i(clk), .srst_i(srst[1]), .req_valid_i(valid[1]), .req_ready_o(ready[1]),
        .req_mask_i(mask[1]), .arst_req_o(arst[1]), .busy_o(busy[1]), .done_o(done[1])
    );

    function automatic int hp(input int d);
        return (d == 0) ? 16 : 1;
    endfunction

    function automatic int gp(input int d);
        return (d == 0) ? 8 : 1;
    endfunction

    task automatic check(input int d, input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s dut%0d cycle %0d: got %0d expected %0d", name, d, cyc, act, exp);
    endtask

    task automatic push(input int d, input int kind, input int idx, input int c);
        ev_t e;
        e.kind = kind;
        e.idx  = idx;
        e.cyc  = c;
        sbq[d].push_back(e);
    endtask

    // Reference model: k-th selected domain falls at t0+1+H+k*G, done one cycle later, ready after that.
    task automatic predict_req(input int d, input int t0, input logic [ND-1:0] m);
        int n = 0;
        int last;
        if (m == '0) begin
            push(d, 1, 0, t0 + 1);
            push(d, 2, 0, t0 + 2);
            return;
        end
        for (int b = 0; b < ND; b++) begin
            if (m[b]) begin
                push(d, 0, b, t0 + 1 + hp(d) + n * gp(d));
                n++;
            end
        end
        last = t0 + 1 + hp(d) + (n - 1) * gp(d);
        push(d, 1, 0, last + 1);
        push(d, 2, 0, last + 2);
    endtask

    task automatic predict_por(input int d, input int r0);
        for (int k = 0; k < ND; k++) push(d, 0, k, r0 + hp(d) + k * gp(d));
        push(d, 2, 0, r0 + hp(d) + (ND - 1) * gp(d) + 1);
    endtask

    task automatic do_reset(input int d, input int len);
        srst[d]  = 1'b1;
        valid[d] = 1'b0;
        sbq[d].delete();
        repeat (len) @(negedge clk);
        check(d, "rst_arst", int'(arst[d]), (1 << ND) - 1);
        check(d, "rst_ready", int'(ready[d]), 0);
        check(d, "rst_busy", int'(busy[d]), 1);
        check(d, "rst_done", int'(done[d]), 0);
        srst[d] = 1'b0;
        predict_por(d, cyc);
    endtask

    task automatic send(input int d, input int fm, input bit hold);
        logic [ND-1:0] m;
        int to = 0;
        valid[d] = 1'b1;
        forever begin
            if (fm >= 0) m = fm[ND-1:0];
            else if ($urandom_range(0, 7) == 0) m = '0;
            else m = ND'($urandom);
            mask[d] = m;
            if (ready[d]) break;
            to++;
            if (to > 400) begin
                check(d, "ready_timeout", 0, 1);
                valid[d] = 1'b0;
                return;
            end
            @(negedge clk);
        end
        predict_req(d, cyc, m);
        @(negedge clk);
        if (!hold) valid[d] = 1'b0;
    endtask

    task automatic run(input int d, input int nreq, input int first_mask);
        int  fm;
        bit  hold;
        bit  abort;
        for (int i = 0; i < nreq; i++) begin
            hold  = ($urandom_range(0, 3) == 0);
            abort = (i >= 2) && ($urandom_range(0, 4) == 0);
            if (i == 0) fm = first_mask;
            else if (i == 1 && d == 0) fm = 0;
            else fm = -1;
            send(d, fm, hold);
            if (abort) begin
                repeat ($urandom_range(1, 20)) @(negedge clk);
                do_reset(d, $urandom_range(1, 3));
            end else if (!hold) begin
                repeat ($urandom_range(0, 4)) @(negedge clk);
            end
        end
        valid[d] = 1'b0;
    endtask

    task automatic post(input int d, input int kind, input int idx);
        ev_t e;
        if (sbq[d].size() == 0) begin
            check(d, "unexpected_event_kind", kind, -1);
            return;
        end
        e = sbq[d].pop_front();
        check(d, "event_kind", kind, e.kind);
        check(d, "event_idx", idx, e.idx);
        check(d, "event_cycle", cyc, e.cyc);
    endtask

    initial begin : monitor
        logic [ND-1:0] pa [2];
        logic          pr [2];
        for (int d = 0; d < 2; d++) begin
            pa[d] = '1;
            pr[d] = 1'b0;
        end
        forever begin
            @(posedge clk);
            #1;
            if (mon_on) begin
                for (int d = 0; d < 2; d++) begin
                    while (sbq[d].size() > 0 && sbq[d][0].cyc < cyc) begin
                        check(d, "missing_event_at", cyc, sbq[d][0].cyc);
                        void'(sbq[d].pop_front());
                    end
                    for (int b = 0; b < ND; b++)
                        if (pa[d][b] && !arst[d][b]) post(d, 0, b);
                    if (done[d]) post(d, 1, 0);
                    if (ready[d] && !pr[d]) post(d, 2, int'(busy[d]));
                    pa[d] = arst[d];
                    pr[d] = ready[d];
                end
            end
        end
    end

    initial begin
        int wait_cyc;
        for (int d = 0; d < 2; d++) begin
            srst[d]  = 1'b1;
            valid[d] = 1'b0;
            mask[d]  = '0;
        end
        fork
            do_reset(0, 2);
            do_reset(1, 2);
        join
        mon_on = 1'b1;
        fork
            run(0, 14, 4'b1010);
            run(1, 12, 4'b1111);
        join
        wait_cyc = 0;
        while ((sbq[0].size() > 0 || sbq[1].size() > 0) && wait_cyc < 300) begin
            @(negedge clk);
            wait_cyc++;
        end
        for (int d = 0; d < 2; d++)
            while (sbq[d].size() > 0) begin
                check(d, "drain_missing_event", cyc, sbq[d][0].cyc);
                void'(sbq[d].pop_front());
            end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
